norm_reader: RTL and testbench

//  Consumer end of the crop path. Drains the cropped OUT_ROWS x OUT_COLS pixel stream from the crop FIFO.

---
 rtl/norm_reader.sv | 191 +++++++++++++++++++
 tb/tb_norm_reader.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/norm_reader.sv
// norm_reader: consumer end of the crop path. Waits for the crop stage's
// frame maximum, computes its reciprocal with a sequential restoring
// divider, then scales every cropped pixel into an unsigned Q1.F word
// through a 2-stage multiply pipeline. The frame ends with tlast and ap_done.
//
// Handshake: on both AXI-Stream ports a beat transfers on a rising edge where
// tvalid && tready are both high. The upstream source holds tvalid/tdata until
// the transfer. This block holds m_axis_tdata/m_axis_tlast stable while
// m_axis_tvalid && !m_axis_tready.
module norm_reader #(
  parameter int PIXEL_BIT_WIDTH = 10,
  parameter int OUT_ROWS        = 10,
  parameter int OUT_COLS        = 10,
  parameter int OUT_FRAC_BITS   = 8
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       ap_start,
  output logic                       ap_ready,
  output logic                       ap_done,
  input  logic                       cf_ap_done,
  input  logic [PIXEL_BIT_WIDTH-1:0] max_value,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [PIXEL_BIT_WIDTH-1:0] s_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [OUT_FRAC_BITS:0]     m_axis_tdata,
  output logic                       m_axis_tlast
);

  localparam int G  = PIXEL_BIT_WIDTH;
  localparam int F  = OUT_FRAC_BITS;
  localparam int Q  = F + G + 1;            // reciprocal / quotient width
  localparam int N  = OUT_ROWS * OUT_COLS;  // beats per frame
  localparam int CW = $clog2(N + 1);
  localparam int DW = $clog2(Q + 1);
  localparam int PW = G + Q;                // full product width
  localparam int OW = F + 1;

  localparam logic [OW-1:0] ONE_Q = {1'b1, {F{1'b0}}};

  // State encoding is visible to debug probes through the 'state' signal.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MAX = 2'd1,
    DIVIDE   = 2'd2,
    STREAM   = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic          max_seen;
  logic [G-1:0]  max_lat;
  logic [DW-1:0] div_cnt;
  logic [G-1:0]  rem;
  logic [Q-1:0]  quo;
  logic [Q-1:0]  recip;
  logic [G:0]    shifted;
  logic          ge;
  logic [CW-1:0] in_cnt;
  logic [CW-1:0] out_cnt;
  logic          last_beat;
  logic          en;
  logic          s_fire;
  logic          m_fire;
  logic          capture;
  logic          enter_stream;
  logic          start_div;
  logic          v1;
  logic [Q-1:0]  scaled1;
  logic          full1;
  logic [Q-1:0]  scaled_in;
  logic [OW-1:0] out_val;

  assign en           = !m_axis_tvalid || m_axis_tready;
  assign s_fire       = s_axis_tvalid && s_axis_tready;
  assign m_fire       = m_axis_tvalid && m_axis_tready;
  assign last_beat    = (out_cnt == CW'(N - 1));
  assign capture      = ((state == IDLE) || (state == WAIT_MAX)) && cf_ap_done;
  assign enter_stream = (state == DIVIDE) && (state_nxt == STREAM);
  assign start_div    = (state != DIVIDE) && (state_nxt == DIVIDE);

  // The dividend is 2**(F+G): only its MSB (consumed on the first step) is 1.
  assign shifted = {rem, (div_cnt == '0)};
  assign ge      = (shifted >= {1'b0, max_lat});
  // A zero maximum would yield an all-ones quotient; force it to zero.
  assign recip   = (max_lat == '0) ? '0 : quo;

  // Upper bits of pixel * reciprocal; the low G bits are the discarded fraction.
  assign scaled_in = Q'((PW'(s_axis_tdata) * PW'(recip)) >> G);

  // State register.
  always_ff @(posedge clk) begin
    if (srst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (ap_start) state_nxt = max_seen ? DIVIDE : WAIT_MAX;
      WAIT_MAX: if (max_seen) state_nxt = DIVIDE;
      DIVIDE:   if (div_cnt == DW'(Q - 1)) state_nxt = STREAM;
      STREAM:   if (m_fire && last_beat) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // FSM-derived outputs.
  always_comb begin
    ap_ready      = (state == IDLE);
    ap_done       = (state == STREAM) && m_fire && last_beat;
    s_axis_tready = (state == STREAM) && en && (in_cnt < CW'(N));
    m_axis_tlast  = m_axis_tvalid && last_beat;
  end

  // Frame maximum capture; consumed when streaming starts.
  always_ff @(posedge clk) begin
    if (srst) begin
      max_seen <= 1'b0;
      max_lat  <= '0;
    end else if (capture) begin
      max_seen <= 1'b1;
      max_lat  <= max_value;
    end else if (enter_stream) begin
      max_seen <= 1'b0;
    end
  end

  // Restoring reciprocal divider, one quotient bit per DIVIDE cycle.
  always_ff @(posedge clk) begin
    if (srst) begin
      div_cnt <= '0;
      rem     <= '0;
      quo     <= '0;
    end else if (start_div) begin
      div_cnt <= '0;
      rem     <= '0;
      quo     <= '0;
    end else if (state == DIVIDE) begin
      div_cnt <= div_cnt + DW'(1);
      rem     <= ge ? G'(shifted - {1'b0, max_lat}) : shifted[G-1:0];
      quo     <= {quo[Q-2:0], ge};
    end
  end

  // Input and output beat counters, restarted for every frame.
  always_ff @(posedge clk) begin
    if (srst || enter_stream) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      if (s_fire) in_cnt <= in_cnt + CW'(1);
      if (m_fire) out_cnt <= out_cnt + CW'(1);
    end
  end

  // Pipeline stage 1: multiply and flag pixels at or above the maximum.
  always_ff @(posedge clk) begin
    if (srst) begin
      v1      <= 1'b0;
      scaled1 <= '0;
      full1   <= 1'b0;
    end else if (en) begin
      v1      <= s_fire;
      scaled1 <= scaled_in;
      full1   <= (s_axis_tdata >= max_lat) && (max_lat != '0);
    end
  end

  // Saturate the scaled value to exactly 1.0.
  always_comb begin
    out_val = scaled1[OW-1:0];
    if (full1 || (scaled1 > {{G{1'b0}}, ONE_Q})) out_val = ONE_Q;
  end

  // Pipeline stage 2: output register, held while downstream stalls.
  always_ff @(posedge clk) begin
    if (srst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (en) begin
      m_axis_tvalid <= v1;
      if (v1) m_axis_tdata <= out_val;
    end
  end

endmodule

// File: tb/tb_norm_reader.sv
// Testbench for norm_reader: randomized pixel frames checked against a
// behavioural model of the normalization rules, with stalls, gaps and resets.
module tb_norm_reader;

  localparam int G  = 10;
  localparam int F  = 8;
  localparam int N  = 100;
  localparam int OW = F + 1;
  localparam logic [1:0] ST_WAIT_MAX = 2'd1;
  localparam logic [1:0] ST_DIVIDE   = 2'd2;
  localparam logic [1:0] ST_STREAM   = 2'd3;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          srst = 1'b1;
  logic          ap_start = 1'b0;
  logic          ap_ready;
  logic          ap_done;
  logic          cf_ap_done = 1'b0;
  logic [G-1:0]  max_value = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [G-1:0]  s_axis_tdata = '0;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [OW-1:0] m_axis_tdata;
  logic          m_axis_tlast;

  int total = 0;
  int bad   = 0;

  int            pix_q[$];
  logic [OW-1:0] exp_q[$];

  norm_reader #(
    .PIXEL_BIT_WIDTH(G), .OUT_ROWS(10), .OUT_COLS(10), .OUT_FRAC_BITS(F)
  ) dut (
    .clk(clk), .srst(srst), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .cf_ap_done(cf_ap_done), .max_value(max_value),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: pixel / max as Q1.F, truncated, capped at 1.0
  function automatic logic [OW-1:0] model(input int pix, input int mx);
    longint rcp, v;
    if (mx == 0) return '0;
    if (pix >= mx) return OW'(1 << F);
    rcp = (longint'(1) << (F + G)) / mx;
    v = (longint'(pix) * rcp) >> G;
    if (v > (1 << F)) v = 1 << F;
    return OW'(v);
  endfunction

  task automatic fill_frame(input int mx, input int hi);
    while (pix_q.size() < N) pix_q.push_back(int'($urandom_range(hi, 0)));
    exp_q.delete();
    foreach (pix_q[i]) exp_q.push_back(model(pix_q[i], mx));
  endtask

  // cf_ap_done pulse with the maximum, then ap_start 'lead' cycles later
  task automatic start_frame(input int mx, input int lead);
    @(negedge clk);
    max_value  = G'(mx);
    cf_ap_done = 1'b1;
    @(negedge clk);
    cf_ap_done = 1'b0;
    repeat (lead - 1) @(negedge clk);
    ap_start = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;
  endtask

  // drive pixels and scoreboard outputs until stop_at beats are taken
  task automatic run_stream(input int rdy_pct, input int gap_pct, input int stop_at);
    int sent = 0;
    int beat = 0;
    int cyc = 0;
    logic s_acc = 1'b0;
    logic stalled = 1'b0;
    logic [OW-1:0] held = '0;
    logic held_last = 1'b0;
    logic [OW-1:0] exp;
    s_axis_tvalid = 1'b0;
    while (beat < stop_at && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (s_acc) s_axis_tvalid = 1'b0;
      if (!s_axis_tvalid && sent < N && int'($urandom_range(99, 0)) >= gap_pct) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = G'(pix_q[sent]);
      end
      m_axis_tready = (int'($urandom_range(99, 0)) < rdy_pct);
      #1;
      if (stalled) begin
        total++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== held || m_axis_tlast !== held_last) begin
          bad++;
          $display("FAIL stall_hold beat=%0d got=%0d/%0b/%0b exp=%0d/1/%0b",
                   beat, m_axis_tdata, m_axis_tvalid, m_axis_tlast, held, held_last);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        total++;
        if (m_axis_tdata !== exp) begin
          bad++;
          $display("FAIL data beat=%0d got=%0d exp=%0d", beat, m_axis_tdata, exp);
        end
        total++;
        if (m_axis_tlast !== (beat == N - 1)) begin
          bad++;
          $display("FAIL tlast beat=%0d got=%0b exp=%0b", beat, m_axis_tlast, beat == N - 1);
        end
        total++;
        if (ap_done !== (beat == N - 1)) begin
          bad++;
          $display("FAIL ap_done beat=%0d got=%0b exp=%0b", beat, ap_done, beat == N - 1);
        end
        beat++;
      end else if (ap_done !== 1'b0) begin
        total++;
        bad++;
        $display("FAIL ap_done_idle beat=%0d got=%0b exp=0", beat, ap_done);
      end
      stalled   = m_axis_tvalid && !m_axis_tready;
      held      = m_axis_tdata;
      held_last = m_axis_tlast;
      s_acc     = s_axis_tvalid && s_axis_tready;
      if (s_acc) sent++;
    end
    total++;
    if (beat != stop_at) begin
      bad++;
      $display("FAIL stream_timeout got=%0d exp=%0d beats", beat, stop_at);
    end
    s_axis_tvalid = 1'b0;
    if (stop_at == N) begin
      m_axis_tready = 1'b1;
      @(negedge clk);
      #1;
      total++;
      if (ap_ready !== 1'b1 || m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0) begin
        bad++;
        $display("FAIL frame_end got=ready%0b/mvalid%0b/sready%0b exp=1/0/0",
                 ap_ready, m_axis_tvalid, s_axis_tready);
      end
      total++;
      if (sent != N) begin
        bad++;
        $display("FAIL input_count got=%0d exp=%0d", sent, N);
      end
    end
  endtask

  task automatic check_idle_outputs(input string name);
    total++;
    if (ap_ready !== 1'b1 || ap_done !== 1'b0 || s_axis_tready !== 1'b0 ||
        m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== '0) begin
      bad++;
      $display("FAIL %s got=rdy%0b done%0b srdy%0b mv%0b last%0b data%0d exp=1/0/0/0/0/0",
               name, ap_ready, ap_done, s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata);
    end
  endtask

  task automatic test_reset();
    srst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset_state");
    srst = 1'b0;
  endtask

  task automatic test_basic();
    pix_q.delete();
    pix_q.push_back(256); pix_q.push_back(512); pix_q.push_back(0); pix_q.push_back(1);
    fill_frame(512, 1023);
    total++;
    if (exp_q[0] !== 9'd128 || exp_q[1] !== 9'd256 || exp_q[2] !== 9'd0 || exp_q[3] !== 9'd0) begin
      bad++;
      $display("FAIL model_t1 got=%0d,%0d,%0d,%0d exp=128,256,0,0", exp_q[0], exp_q[1], exp_q[2], exp_q[3]);
    end
    start_frame(512, 1);
    run_stream(100, 0, N);
  endtask

  task automatic test_divide();
    int div_cycles = 0;
    int cyc = 0;
    logic [18:0] exp_recip;
    pix_q.delete();
    pix_q.push_back(1); pix_q.push_back(2); pix_q.push_back(3);
    fill_frame(3, 5);
    exp_recip = 19'((1 << (F + G)) / 3);
    @(negedge clk);
    max_value = 10'd3; cf_ap_done = 1'b1;
    @(negedge clk);
    cf_ap_done = 1'b0; ap_start = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;
    while (dut.state != ST_STREAM && cyc < 100) begin
      if (dut.state == ST_DIVIDE) div_cycles++;
      @(negedge clk);
      cyc++;
    end
    total++;
    if (div_cycles != F + G + 1) begin
      bad++;
      $display("FAIL divide_cycles got=%0d exp=%0d", div_cycles, F + G + 1);
    end
    total++;
    if (dut.recip !== exp_recip) begin
      bad++;
      $display("FAIL recip got=%0d exp=%0d", dut.recip, exp_recip);
    end
    run_stream(100, 0, N);
  endtask

  task automatic test_max_zero();
    pix_q.delete();
    fill_frame(0, 1023);
    start_frame(0, 2);
    run_stream(80, 10, N);
  endtask

  task automatic test_random_stall();
    for (int k = 0; k < 2; k++) begin
      int mx;
      mx = int'($urandom_range(1023, 1));
      pix_q.delete();
      fill_frame(mx, 1023);
      start_frame(mx, 1);
      run_stream(50, 40, N);
    end
  endtask

  task automatic test_start_order();
    int mx;
    int cyc = 0;
    mx = int'($urandom_range(1023, 1));
    pix_q.delete();
    fill_frame(mx, 1023);
    start_frame(mx, 5);
    total++;
    if (dut.state !== ST_DIVIDE) begin
      bad++;
      $display("FAIL skip_wait got=%0d exp=%0d", dut.state, ST_DIVIDE);
    end
    run_stream(70, 20, N);

    mx = int'($urandom_range(1023, 1));
    pix_q.delete();
    fill_frame(mx, 1023);
    @(negedge clk);
    ap_start = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;
    repeat (18) @(negedge clk);
    total++;
    if (dut.state !== ST_WAIT_MAX) begin
      bad++;
      $display("FAIL waits_for_max got=%0d exp=%0d", dut.state, ST_WAIT_MAX);
    end
    max_value = G'(mx); cf_ap_done = 1'b1;
    @(negedge clk);
    cf_ap_done = 1'b0;
    while (dut.state != ST_DIVIDE && cyc < 5) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (dut.state !== ST_DIVIDE) begin
      bad++;
      $display("FAIL leave_wait got=%0d exp=%0d", dut.state, ST_DIVIDE);
    end
    run_stream(70, 20, N);
  endtask

  task automatic test_reset_mid();
    int mx;
    mx = int'($urandom_range(1023, 1));
    pix_q.delete();
    fill_frame(mx, 1023);
    start_frame(mx, 1);
    run_stream(70, 20, 40);
    @(negedge clk);
    srst = 1'b1; s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
    @(negedge clk);
    #1;
    check_idle_outputs("mid_frame_reset");
    srst = 1'b0;
    mx = int'($urandom_range(1023, 1));
    pix_q.delete();
    fill_frame(mx, 1023);
    start_frame(mx, 3);
    run_stream(60, 30, N);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_divide();
    test_max_zero();
    test_random_stall();
    test_start_order();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
